// File: rtl/hazard_ctrl.sv
// hazard_ctrl: interlock and forwarding controller for a 5-stage pipeline
// (IFU -> decode -> exec -> mem -> write). Branches and operands resolve in
// decode, so forwarding selects feed the ID stage. A small RUN/MD_BUSY state
// machine holds the pipe while a multi-cycle mul/div op occupies exec.
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding. When it is
// undefined, fwd_a/fwd_b stay 00 and every RAW match against EX, MEM or WB
// stalls decode until the producer has written the register file.
//
// Mul/div timing: the op occupies EX for MD_CYCLES cycles. The pipe is held
// for the first MD_CYCLES-1 of them (the RUN entry cycle plus the MD_BUSY
// cycles with cnt != 0). The MD_BUSY cycle with cnt == 0 is the op's last EX
// cycle: it is not held, so the op drains to MEM at the next edge and the
// state machine is back in RUN before ex_muldiv can be seen again.
module hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use1,
    input  logic       id_use2,
    input  logic [4:0] ex_rw,
    input  logic       ex_regwrite,
    input  logic       ex_muldiv,
    input  logic [4:0] mem_rw,
    input  logic       mem_regwrite,
    input  logic       mem_mem2reg,
    input  logic [4:0] wb_rw,
    input  logic       wb_regwrite,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_bubble,
    output logic       ex_hold,
    output logic       exmem_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_busy
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic ex_hit, mem_hit, wb_hit, load_hit;
    logic busy_stall;
    logic haz_stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    // RAW match of one ID source against one producer; r0 never hazards.
    function automatic logic raw_match(input logic       use_src,
                                       input logic [4:0] rs,
                                       input logic       regwrite,
                                       input logic [4:0] rw);
        raw_match = use_src & regwrite & (rs == rw) & (rs != 5'd0);
    endfunction

    // State and mul/div counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: enter MD_BUSY on a mul/div in RUN; ex_muldiv is ignored in MD_BUSY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (ex_muldiv) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Hazard detection and forwarding selects for the ID operands.
    always_comb begin
        ex_hit1  = raw_match(id_use1, id_rs1, ex_regwrite, ex_rw);
        ex_hit2  = raw_match(id_use2, id_rs2, ex_regwrite, ex_rw);
        mem_hit1 = raw_match(id_use1, id_rs1, mem_regwrite, mem_rw);
        mem_hit2 = raw_match(id_use2, id_rs2, mem_regwrite, mem_rw);
        wb_hit1  = raw_match(id_use1, id_rs1, wb_regwrite, wb_rw);
        wb_hit2  = raw_match(id_use2, id_rs2, wb_regwrite, wb_rw);

        ex_hit   = ex_hit1 | ex_hit2;
        mem_hit  = mem_hit1 | mem_hit2;
        wb_hit   = wb_hit1 | wb_hit2;
        // Load data is not available until WB, so a MEM load match must stall.
        load_hit = mem_hit & mem_mem2reg;

`ifdef HAZARD_FWD_EN
        haz_stall = ex_hit | load_hit;
        // Nearest producer first: MEM ALU result beats the WB bus.
        if (mem_hit1 && !mem_mem2reg) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_hit1) begin
            fwd_a_sel = FWD_WB;
        end else begin
            fwd_a_sel = FWD_RF;
        end
        if (mem_hit2 && !mem_mem2reg) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_hit2) begin
            fwd_b_sel = FWD_WB;
        end else begin
            fwd_b_sel = FWD_RF;
        end
`else
        // Without forwarding, decode waits until the producer has left WB
        // (load_hit is already covered by mem_hit here).
        haz_stall = ex_hit | load_hit | mem_hit | wb_hit;
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
`endif

        busy_stall = ((state == RUN) && ex_muldiv) ||
                     ((state == MD_BUSY) && (cnt != '0));
    end

    // Output decode: reset forces all zero, mul/div hold wins over ID hazards.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_bubble  = 1'b0;
        ex_hold      = 1'b0;
        exmem_bubble = 1'b0;
        md_busy      = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        if (!reset) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (busy_stall) begin
                // ID/EX is held rather than bubbled so the mul/div op stays in EX.
                md_busy      = 1'b1;
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                ex_hold      = 1'b1;
                exmem_bubble = 1'b1;
            end else if (haz_stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

endmodule
